// File: rtl/f9pcap_unwrap_eth.sv
// f9pcap receive unwrapper: validates the Eth/IPv4/UDP + f9phdr wrapper, strips its 58 bytes
// and realigns the captured frame to lane 0 with timestamp/port sideband (64-bit stream only).
module f9pcap_unwrap_eth #(
  parameter int          DATA_WIDTH   = 64,
  parameter int          TTS_WIDTH    = 56,
  parameter logic [15:0] UDP_DST_PORT = 16'h789a,
  parameter int          CNT_WIDTH    = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    i_valid_in,
  output logic                    i_ready_out,
  input  logic [DATA_WIDTH-1:0]   i_data_in,
  input  logic [DATA_WIDTH/8-1:0] i_keep_in,
  input  logic                    i_last_in,
  output logic                    o_valid_out,
  input  logic                    o_ready_in,
  output logic [DATA_WIDTH-1:0]   o_data_out,
  output logic [DATA_WIDTH/8-1:0] o_keep_out,
  output logic                    o_last_out,
  output logic                    o_err_out,
  output logic [TTS_WIDTH-1:0]    o_tts_out,
  output logic [7:0]              o_port_id_out,
  output logic [CNT_WIDTH-1:0]    cnt_ok_out,
  output logic [CNT_WIDTH-1:0]    cnt_drop_out
);

  // state   | meaning
  // HDR     | header beats 0..6, field checks
  // ALIGN   | beat 7, first 6 payload bytes into hold
  // PAYLOAD | emit {cur[1:0], hold[5:0]} per beat
  // FLUSH   | emit hold residue after input ended
  // DROP    | discard to i_last_in (counted or pad)
  localparam logic [2:0] ST_HDR     = 3'd0;
  localparam logic [2:0] ST_ALIGN   = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_FLUSH   = 3'd3;
  localparam logic [2:0] ST_DROP    = 3'd4;

  logic [2:0]  state_q;
  logic [2:0]  beat_q;
  logic [15:0] len_q;
  logic [15:0] emit_q;
  logic [47:0] hold_q;
  logic [3:0]  flush_n_q;
  logic        flush_err_q;
  logic        drop_cnt_q;
  logic        frame_err_q;

  function automatic logic [7:0] keep_mask(input logic [3:0] n);
    return 8'((9'd1 << n) - 9'd1);
  endfunction

  function automatic logic [63:0] lane_mask(input logic [7:0] k);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  function automatic logic [3:0] popcnt8(input logic [7:0] k);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'd0, k[i]};
    return c;
  endfunction

  logic        out_free, acc, hdr_ok, short_f, al_short;
  logic [3:0]  n_in, this_n, left_n, pay_n, al_n;
  logic [4:0]  avail;
  logic [15:0] rem, owed, len_in;

  assign out_free    = ~o_valid_out | o_ready_in;
  assign i_ready_out = (state_q == ST_DROP) | (out_free & (state_q != ST_FLUSH));
  assign acc         = i_valid_in & i_ready_out;
  assign n_in        = popcnt8(i_keep_in);
  assign len_in      = {i_data_in[23:16], i_data_in[31:24]};

  always_comb begin
    hdr_ok = 1'b1;
    case (beat_q)
      3'd1: hdr_ok = (i_data_in[39:32] == 8'h08) && (i_data_in[47:40] == 8'h00) &&
                     (i_data_in[55:48] == 8'h45);
      3'd2: hdr_ok = (i_data_in[63:56] == 8'd17);
      3'd4: hdr_ok = ({i_data_in[39:32], i_data_in[47:40]} == UDP_DST_PORT);
      3'd6: hdr_ok = (len_in != 16'd0);
      default: hdr_ok = 1'b1;
    endcase
  end

  // hold always carries 6 bytes in PAYLOAD, so this beat can owe up to 6+n bytes
  assign rem     = len_q - emit_q;
  assign avail   = 5'd6 + {1'b0, n_in};
  assign short_f = {11'd0, avail} < rem;
  assign owed    = short_f ? {11'd0, avail} : rem;
  assign this_n  = (owed > 16'd8) ? 4'd8 : owed[3:0];
  assign left_n  = owed[3:0] - this_n;

  assign pay_n    = (n_in > 4'd2) ? n_in - 4'd2 : 4'd0;
  assign al_short = {12'd0, pay_n} < len_q;
  assign al_n     = al_short ? pay_n : len_q[3:0];

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q       <= ST_HDR;
      beat_q        <= 3'd0;
      len_q         <= 16'd0;
      emit_q        <= 16'd0;
      hold_q        <= 48'd0;
      flush_n_q     <= 4'd0;
      flush_err_q   <= 1'b0;
      drop_cnt_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      o_valid_out   <= 1'b0;
      o_data_out    <= '0;
      o_keep_out    <= '0;
      o_last_out    <= 1'b0;
      o_err_out     <= 1'b0;
      o_tts_out     <= '0;
      o_port_id_out <= 8'd0;
      cnt_ok_out    <= '0;
      cnt_drop_out  <= '0;
    end else begin
      if (out_free) o_valid_out <= 1'b0;
      if (o_valid_out & o_ready_in & o_last_out) cnt_ok_out <= cnt_ok_out + CNT_WIDTH'(1);

      if ((state_q == ST_FLUSH) && out_free) begin
        o_valid_out <= 1'b1;
        o_data_out  <= {16'd0, hold_q} & lane_mask(keep_mask(flush_n_q));
        o_keep_out  <= keep_mask(flush_n_q);
        o_last_out  <= 1'b1;
        o_err_out   <= flush_err_q;
        state_q     <= ST_HDR;
        beat_q      <= 3'd0;
      end

      if (acc) begin
        case (state_q)
          ST_HDR: begin
            if (beat_q == 3'd5)
              o_tts_out[55:8] <= {i_data_in[23:16], i_data_in[31:24], i_data_in[39:32],
                                  i_data_in[47:40], i_data_in[55:48], i_data_in[63:56]};
            if (beat_q == 3'd6) begin
              o_tts_out[7:0] <= i_data_in[7:0];
              o_port_id_out  <= i_data_in[15:8];
              len_q          <= len_in;
              frame_err_q    <= i_data_in[32];
            end
            if (i_last_in) begin
              cnt_drop_out <= cnt_drop_out + CNT_WIDTH'(1);
              beat_q       <= 3'd0;
            end else if (!hdr_ok) begin
              state_q    <= ST_DROP;
              drop_cnt_q <= 1'b1;
              beat_q     <= 3'd0;
            end else if (beat_q == 3'd6) begin
              state_q <= ST_ALIGN;
              beat_q  <= 3'd0;
            end else begin
              beat_q <= beat_q + 3'd1;
            end
          end
          ST_ALIGN: begin
            hold_q <= i_data_in[63:16];
            emit_q <= 16'd0;
            if (!i_last_in) begin
              state_q <= ST_PAYLOAD;
            end else if (pay_n == 4'd0) begin
              cnt_drop_out <= cnt_drop_out + CNT_WIDTH'(1);
              state_q      <= ST_HDR;
            end else begin
              state_q     <= ST_FLUSH;
              flush_n_q   <= al_n;
              flush_err_q <= al_short | frame_err_q;
            end
          end
          ST_PAYLOAD: begin
            hold_q      <= i_data_in[63:16];
            o_valid_out <= 1'b1;
            o_data_out  <= {i_data_in[15:0], hold_q} & lane_mask(keep_mask(this_n));
            o_keep_out  <= keep_mask(this_n);
            if (left_n == 4'd0) begin
              o_last_out <= 1'b1;
              o_err_out  <= frame_err_q | short_f;
              state_q    <= i_last_in ? ST_HDR : ST_DROP;
              drop_cnt_q <= 1'b0;
            end else begin
              o_last_out <= 1'b0;
              o_err_out  <= 1'b0;
              emit_q     <= emit_q + 16'd8;
              if (i_last_in) begin
                state_q     <= ST_FLUSH;
                flush_n_q   <= left_n;
                flush_err_q <= frame_err_q | short_f;
              end
            end
          end
          ST_DROP: begin
            if (i_last_in) begin
              if (drop_cnt_q) cnt_drop_out <= cnt_drop_out + CNT_WIDTH'(1);
              state_q <= ST_HDR;
              beat_q  <= 3'd0;
            end
          end
          default: begin
            state_q <= ST_HDR;
            beat_q  <= 3'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_f9pcap_unwrap_eth.sv
// Directed bench for f9pcap_unwrap_eth: a table of wrapped frames with hand-computed outcomes,
// plus a mid-frame reset sequence.
module tb_f9pcap_unwrap_eth;
  logic        clk_in     = 1'b0;
  logic        rst_n_in   = 1'b0;
  logic        i_valid_in = 1'b0;
  logic        i_ready_out;
  logic [63:0] i_data_in  = '0;
  logic [7:0]  i_keep_in  = '0;
  logic        i_last_in  = 1'b0;
  logic        o_valid_out;
  logic        o_ready_in = 1'b1;
  logic [63:0] o_data_out;
  logic [7:0]  o_keep_out;
  logic        o_last_out;
  logic        o_err_out;
  logic [55:0] o_tts_out;
  logic [7:0]  o_port_id_out;
  logic [31:0] cnt_ok_out;
  logic [31:0] cnt_drop_out;

  f9pcap_unwrap_eth dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .i_valid_in(i_valid_in), .i_ready_out(i_ready_out), .i_data_in(i_data_in),
    .i_keep_in(i_keep_in), .i_last_in(i_last_in),
    .o_valid_out(o_valid_out), .o_ready_in(o_ready_in), .o_data_out(o_data_out),
    .o_keep_out(o_keep_out), .o_last_out(o_last_out), .o_err_out(o_err_out),
    .o_tts_out(o_tts_out), .o_port_id_out(o_port_id_out),
    .cnt_ok_out(cnt_ok_out), .cnt_drop_out(cnt_drop_out)
  );

  typedef struct {
    logic [15:0] len;
    int          total;
    logic [15:0] udp;
    logic [7:0]  eth_hi;
    logic        ferr;
    logic [55:0] tts;
    logic [7:0]  pid;
    logic [7:0]  seed;
    logic        bp;
    logic        exp_drop;
    int          exp_bytes;
    logic        exp_err;
  } vec_t;

  int   n_vec = 0, n_err = 0, exp_ok = 0, exp_drop = 0, stall_bad = 0;
  logic bp_mode = 1'b0, abort = 1'b0;
  logic [7:0]  fb[$];
  logic [63:0] rx_d[$];
  logic [7:0]  rx_k[$];
  logic        rx_l[$];
  logic        rx_e[$];
  logic [55:0] rx_t[$];
  logic [7:0]  rx_p[$];
  logic        prev_stall = 1'b0, prev_l = 1'b0;
  logic [63:0] prev_d = '0;
  logic [7:0]  prev_k = '0;

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) o_ready_in = bp_mode ? ~o_ready_in : 1'b1;

  always @(negedge clk_in) begin
    #4;
    if (prev_stall && (!o_valid_out || o_data_out != prev_d || o_keep_out != prev_k ||
                       o_last_out != prev_l))
      stall_bad++;
    prev_stall = o_valid_out && !o_ready_in;
    prev_d = o_data_out;
    prev_k = o_keep_out;
    prev_l = o_last_out;
    if (o_valid_out && o_ready_in) begin
      rx_d.push_back(o_data_out);
      rx_k.push_back(o_keep_out);
      rx_l.push_back(o_last_out);
      rx_e.push_back(o_err_out);
      rx_t.push_back(o_tts_out);
      rx_p.push_back(o_port_id_out);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] wire_byte(input vec_t v, input int i);
    if (i >= 58) return 8'(v.seed + 8'(i - 58));
    if (i == 12) return v.eth_hi;
    if (i == 13) return 8'h00;
    if (i == 14) return 8'h45;
    if (i == 23) return 8'd17;
    if (i == 36) return v.udp[15:8];
    if (i == 37) return v.udp[7:0];
    if (i >= 42 && i <= 48) return v.tts[8*(48-i) +: 8];
    if (i == 49) return v.pid;
    if (i == 50) return v.len[15:8];
    if (i == 51) return v.len[7:0];
    if (i == 52) return {7'd0, v.ferr};
    return 8'(i * 3 + 1);
  endfunction

  task automatic build(input vec_t v);
    fb.delete();
    for (int i = 0; i < v.total; i++) fb.push_back(wire_byte(v, i));
  endtask

  task automatic send_frame();
    int nb;
    nb = (fb.size() + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      logic [63:0] d;
      logic [7:0]  k;
      logic        acc_f;
      int          guard;
      d = '0;
      k = '0;
      for (int j = 0; j < 8; j++)
        if (8*b + j < fb.size()) begin
          d[8*j +: 8] = fb[8*b + j];
          k[j] = 1'b1;
        end
      @(negedge clk_in);
      if (abort) break;
      i_valid_in = 1'b1;
      i_data_in  = d;
      i_keep_in  = k;
      i_last_in  = (b == nb - 1);
      acc_f = 1'b0;
      guard = 0;
      while (!acc_f && !abort && guard < 200) begin
        #4;
        if (abort) break;
        if (i_ready_out) acc_f = 1'b1;
        else begin
          @(negedge clk_in);
          guard++;
        end
      end
      if (abort) break;
      if (!acc_f) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: beat %0d not accepted", b);
        break;
      end
    end
    @(negedge clk_in);
    i_valid_in = 1'b0;
    i_last_in  = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int base, nb, got;
    build(v);
    base = rx_d.size();
    bp_mode = v.bp;
    send_frame();
    nb = v.exp_drop ? 0 : (v.exp_bytes + 7) / 8;
    for (int c = 0; c < 100 && (rx_d.size() - base) < nb; c++) @(negedge clk_in);
    repeat (6) @(negedge clk_in);
    bp_mode = 1'b0;
    got = rx_d.size() - base;
    chk($sformatf("v%0d_beats", idx), 64'(got), 64'(nb));
    if (v.exp_drop) exp_drop++;
    else exp_ok++;
    for (int k = 0; k < nb && k < got; k++) begin
      logic [63:0] ed;
      logic [7:0]  ek;
      logic        el;
      ed = '0;
      ek = '0;
      for (int j = 0; j < 8; j++)
        if (8*k + j < v.exp_bytes) begin
          ed[8*j +: 8] = 8'(v.seed + 8'(8*k + j));
          ek[j] = 1'b1;
        end
      el = (k == nb - 1);
      chk($sformatf("v%0d_b%0d_data", idx, k), rx_d[base+k], ed);
      chk($sformatf("v%0d_b%0d_keep", idx, k), 64'(rx_k[base+k]), 64'(ek));
      chk($sformatf("v%0d_b%0d_last", idx, k), 64'(rx_l[base+k]), 64'(el));
      chk($sformatf("v%0d_b%0d_err", idx, k), 64'(rx_e[base+k]), 64'(el & v.exp_err));
      chk($sformatf("v%0d_b%0d_tts", idx, k), 64'(rx_t[base+k]), 64'(v.tts));
      chk($sformatf("v%0d_b%0d_port", idx, k), 64'(rx_p[base+k]), 64'(v.pid));
    end
    chk($sformatf("v%0d_cnt_ok", idx), 64'(cnt_ok_out), 64'(exp_ok));
    chk($sformatf("v%0d_cnt_drop", idx), 64'(cnt_drop_out), 64'(exp_drop));
  endtask

  initial begin
    vec_t tbl [15];
    vec_t vr;
    int   base, lasts;
    //          len     total udp       eth    ferr tts                pid    seed   bp drop bytes err
    tbl[0]  = '{16'd32,  90, 16'h789a, 8'h08, 0, 56'h00000000012345, 8'd1, 8'h00, 0, 0, 32,  0};
    tbl[1]  = '{16'd33,  91, 16'h789a, 8'h08, 0, 56'h00000000012345, 8'd1, 8'h00, 0, 0, 33,  0};
    tbl[2]  = '{16'd6,   64, 16'h789a, 8'h08, 0, 56'h11223344556677, 8'd2, 8'h30, 0, 0, 6,   0};
    tbl[3]  = '{16'd32,  90, 16'h1234, 8'h08, 0, 56'h0000000000abcd, 8'd3, 8'h00, 0, 1, 0,   0};
    tbl[4]  = '{16'd20,  78, 16'h789a, 8'h08, 0, 56'h0102030405060d, 8'd4, 8'h50, 0, 0, 20,  0};
    tbl[5]  = '{16'd100, 158, 16'h789a, 8'h08, 0, 56'hfedcba98765432, 8'd5, 8'h40, 1, 0, 100, 0};
    tbl[6]  = '{16'd32,  40, 16'h789a, 8'h08, 0, 56'h00000000000001, 8'd6, 8'h00, 0, 1, 0,   0};
    tbl[7]  = '{16'd16,  74, 16'h789a, 8'h08, 1, 56'h000000000000ee, 8'd7, 8'h70, 0, 0, 16,  1};
    tbl[8]  = '{16'd50,  78, 16'h789a, 8'h08, 0, 56'h00000000000088, 8'd8, 8'h80, 0, 0, 20,  1};
    tbl[9]  = '{16'd10,  88, 16'h789a, 8'h08, 0, 56'h00000000000099, 8'd9, 8'h90, 0, 0, 10,  0};
    tbl[10] = '{16'd0,   70, 16'h789a, 8'h08, 0, 56'h000000000000aa, 8'd10, 8'ha0, 0, 1, 0,  0};
    tbl[11] = '{16'd6,   80, 16'h789a, 8'h08, 0, 56'h000000000000bb, 8'd11, 8'hb0, 0, 0, 6,  0};
    tbl[12] = '{16'd16,  74, 16'h789a, 8'h86, 0, 56'h000000000000cc, 8'd12, 8'hc0, 0, 1, 0,  0};
    tbl[13] = '{16'd3,   61, 16'h789a, 8'h08, 0, 56'h000000000000dd, 8'd13, 8'hd0, 0, 0, 3,  0};
    tbl[14] = '{16'd9,   65, 16'h789a, 8'h08, 0, 56'h000000000000ef, 8'd14, 8'he0, 0, 0, 7,  1};

    repeat (3) @(negedge clk_in);
    #4;
    chk("rst_o_valid", 64'(o_valid_out), 64'd0);
    chk("rst_o_data", o_data_out, 64'd0);
    chk("rst_o_keep", 64'(o_keep_out), 64'd0);
    chk("rst_o_last", 64'(o_last_out), 64'd0);
    chk("rst_o_tts", 64'(o_tts_out), 64'd0);
    chk("rst_cnt_ok", 64'(cnt_ok_out), 64'd0);
    chk("rst_cnt_drop", 64'(cnt_drop_out), 64'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    chk("first_beat_const", 64'(wire_byte(tbl[0], 58 + 7)), 64'h07);
    for (int i = 0; i < 15; i++) run_vec(i, tbl[i]);
    chk("stall_hold", 64'(stall_bad), 64'd0);

    // Mid-frame reset once the third output beat is due
    vr = '{16'd64, 122, 16'h789a, 8'h08, 0, 56'h00000000777777, 8'd20, 8'h10, 0, 0, 64, 0};
    build(vr);
    base = rx_d.size();
    fork
      send_frame();
      begin
        for (int c = 0; c < 100 && (rx_d.size() - base) < 2; c++) @(negedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b0;
        abort    = 1'b1;
        @(negedge clk_in);
        rst_n_in = 1'b1;
      end
    join
    abort = 1'b0;
    #4;
    chk("midrst_reached_beat2", 64'((rx_d.size() - base) >= 2), 64'd1);
    chk("midrst_o_valid", 64'(o_valid_out), 64'd0);
    chk("midrst_o_data", o_data_out, 64'd0);
    chk("midrst_o_tts", 64'(o_tts_out), 64'd0);
    chk("midrst_cnt_ok", 64'(cnt_ok_out), 64'd0);
    chk("midrst_cnt_drop", 64'(cnt_drop_out), 64'd0);
    lasts = 0;
    for (int k = base; k < rx_l.size(); k++) lasts += int'(rx_l[k]);
    chk("midrst_no_last", 64'(lasts), 64'd0);
    exp_ok   = 0;
    exp_drop = 0;
    run_vec(15, tbl[0]);
    run_vec(16, tbl[7]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
